// File: rtl/periph_fifo_drainer.sv
// Drains a remote push/pop FIFO slave over the peripheral bus into a local valid/ready stream.
// Optional PERIPH_FIFO_DRAINER_STATS_EN adds transfer and empty-poll counters.
module periph_fifo_drainer #(
    parameter logic [31:0] BaseAddr     = 32'h0000_0000,
    parameter int unsigned BufDepth     = 4,
    parameter int unsigned MaxBurst     = 4,
    parameter int unsigned PollInterval = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic        req_o,
    output logic [31:0] add_o,
    output logic        wen_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    input  logic        gnt_i,
    input  logic        r_valid_i,
    input  logic [31:0] r_rdata_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
`ifdef PERIPH_FIFO_DRAINER_STATS_EN
    output logic [31:0] words_o,
    output logic [31:0] empty_polls_o,
`endif
    output logic        busy_o
);
    localparam int PW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int CW = $clog2(BufDepth + 1);

    typedef enum logic [2:0] {IDLE, POLL, POLL_W, POP, POP_W} state_t;

    state_t        state, state_nxt;
    logic [31:0]   remaining, remaining_nxt;
    logic [31:0]   timer, timer_nxt;
    logic [31:0]   mem [BufDepth];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    logic [31:0]   free_words, n_words;
    logic          orphan;

    assign req_o   = (state == POLL) || (state == POP);
    assign add_o   = BaseAddr + (((state == POLL) || (state == POLL_W)) ? 32'd4 : 32'd0);
    assign wen_o   = 1'b1;
    assign wdata_o = '0;
    assign be_o    = 4'hF;
    assign busy_o  = (state != IDLE);
    assign valid_o = (count != '0);
    assign data_o  = mem[rd_ptr];
    assign pop     = valid_o && ready_i;

    // Burst size is the credit: never pop more than currently fits in the buffer.
    always_comb begin
        free_words = 32'(BufDepth) - 32'(count);
        n_words    = r_rdata_i;
        if (n_words > 32'(MaxBurst)) n_words = 32'(MaxBurst);
        if (n_words > free_words)    n_words = free_words;
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        timer_nxt     = timer;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (timer != '0)  timer_nxt = timer - 32'd1;
                else if (en_i)    state_nxt = POLL;
            end
            POLL: if (gnt_i) state_nxt = POLL_W;
            POLL_W: begin
                if (r_valid_i) begin
                    if (n_words == '0) begin
                        timer_nxt = 32'(PollInterval);
                        state_nxt = IDLE;
                    end else if (en_i) begin
                        remaining_nxt = n_words;
                        state_nxt     = POP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            POP: if (gnt_i) state_nxt = POP_W;
            POP_W: begin
                if (r_valid_i) begin
                    push          = 1'b1;
                    remaining_nxt = remaining - 32'd1;
                    if (remaining > 32'd1 && en_i) state_nxt = POP;
                    else if (en_i)                 state_nxt = POLL;
                    else                           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            remaining <= '0;
            timer     <= '0;
            // Remembers that a response may still be in flight so its late arrival is expected.
            orphan    <= (orphan || busy_o) && !r_valid_i;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            timer     <= timer_nxt;
            if (r_valid_i) orphan <= 1'b0;
            assert (!(r_valid_i && state != POLL_W && state != POP_W && !orphan))
                else $error("r_valid_i with no transaction outstanding");
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < BufDepth; i++) mem[i] <= '0;
        end else begin
            assert (!(push && !pop && count == CW'(BufDepth)))
                else $error("push into full output buffer");
            if (push) begin
                mem[wr_ptr] <= r_rdata_i;
                wr_ptr      <= (wr_ptr == PW'(BufDepth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(BufDepth - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

`ifdef PERIPH_FIFO_DRAINER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            words_o       <= '0;
            empty_polls_o <= '0;
        end else begin
            if (pop) words_o <= words_o + 32'd1;
            if (state == POLL_W && r_valid_i && r_rdata_i == '0)
                empty_polls_o <= empty_polls_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_periph_fifo_drainer.sv
// Directed bench: a bus slave model feeds a scoreboard queue that is checked against the output stream.
module tb_periph_fifo_drainer;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int PI = 8;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, ready_i;
    logic        gnt_i = 1'b0, r_valid_i = 1'b0;
    logic [31:0] r_rdata_i = '0;
    logic        req_o, wen_o, valid_o, busy_o;
    logic [31:0] add_o, wdata_o, data_o;
    logic [3:0]  be_o;
`ifdef PERIPH_FIFO_DRAINER_STATS_EN
    logic [31:0] words_o, empty_polls_o;
`endif

    periph_fifo_drainer #(.BaseAddr(BASE), .BufDepth(4), .MaxBurst(4), .PollInterval(PI)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
        .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
`ifdef PERIPH_FIFO_DRAINER_STATS_EN
        .words_o(words_o), .empty_polls_o(empty_polls_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0, cyc = 0;
    int pop_cnt = 0, poll_cnt = 0, avail = 0, gnt_delay = 0, resp_delay = 1;
    int resp_cnt = 0, wait_cnt = 0, spacing_checks = 0, pop_wait_cycles = 0;
    int empty_cnt = 0, xfer_cnt = 0, last_poll_cyc = 0;
    logic chk_spacing = 1'b0, last_poll_empty = 1'b0, gnt_prev = 1'b0;
    logic [31:0] word = 32'hA0, resp_data = '0, hold_add = '0;
    logic [31:0] exp_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model and stream monitor; inputs change on the falling edge.
    always @(negedge clk_i) begin
        gnt_i     = 1'b0;
        r_valid_i = 1'b0;
        if (gnt_prev) check("req_drop_after_gnt", 32'(req_o), 32'd0);
        gnt_prev = 1'b0;
        if (rst_i) begin
            exp_q.delete();
            xfer_cnt  = 0;
            empty_cnt = 0;
        end else if (valid_o && ready_i) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check("stream_unexpected", 32'(valid_o), 32'd0);
            else                   check("stream_data", data_o, exp_q.pop_front());
        end
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                r_valid_i = 1'b1;
                r_rdata_i = resp_data;
            end
        end
        if (req_o) begin
            check("wen_read", 32'(wen_o), 32'd1);
            if (wait_cnt == 0) hold_add = add_o;
            else begin
                check("req_add_stable", add_o, hold_add);
                if (add_o == BASE) pop_wait_cycles++;
            end
            if (wait_cnt < gnt_delay) wait_cnt++;
            else begin
                gnt_i    = 1'b1;
                gnt_prev = 1'b1;
                wait_cnt = 0;
                resp_cnt = resp_delay;
                if (add_o == BASE + 32'd4) begin
                    resp_data = (avail > pop_cnt) ? 32'(avail - pop_cnt) : 32'd0;
                    if (chk_spacing && last_poll_empty) begin
                        check("poll_spacing", 32'(cyc - last_poll_cyc), 32'(PI + 3));
                        spacing_checks++;
                    end
                    last_poll_empty = (resp_data == 0);
                    last_poll_cyc   = cyc;
                    if (resp_data == 0) empty_cnt++;
                    poll_cnt++;
                end else begin
                    resp_data = word;
                    word      = word + 32'd1;
                    exp_q.push_back(resp_data);
                    pop_cnt++;
                end
            end
        end else if (wait_cnt > 0) begin
            check("req_withdrawn", 32'(req_o), 32'd1);
            wait_cnt = 0;
        end
    end

    int p0, pl, s0;
    logic [31:0] w0;

    initial begin
        rst_i = 1'b1; en_i = 1'b0; ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_add", add_o, BASE);
        check("rst_wen", 32'(wen_o), 32'd1);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_be", 32'(be_o), 32'hF);
        check("rst_data", data_o, 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;

        // Usage 3, zero-wait slave, stream ready.
        avail = 3; ready_i = 1'b1; en_i = 1'b1;
        for (int i = 0; i < 50 && pop_cnt < 1; i++) begin @(posedge clk_i); #1; end
        check("first_pop_seen", 32'(pop_cnt), 32'd1);
        check("valid_before_resp", 32'(valid_o), 32'd0);
        @(posedge clk_i); #1;
        check("valid_after_resp", 32'(valid_o), 32'd1);
        check("first_word", data_o, 32'hA0);
        for (int i = 0; i < 50 && pop_cnt < 3; i++) begin @(posedge clk_i); #1; end
        @(posedge clk_i); #1;
        check("repoll_req", 32'(req_o), 32'd1);
        check("repoll_addr", add_o, BASE + 32'd4);
        repeat (10) begin @(posedge clk_i); #1; end
        check("t1_pops", 32'(pop_cnt), 32'd3);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Empty slave: polls spaced by the interval, never a pop.
        chk_spacing = 1'b1; p0 = poll_cnt; s0 = spacing_checks;
        for (int i = 0; i < 200 && poll_cnt < p0 + 4; i++) begin @(posedge clk_i); #1; end
        check("spacing_seen", 32'(spacing_checks - s0 >= 3), 32'd1);
        check("no_pop_when_empty", 32'(pop_cnt), 32'd3);
`ifdef PERIPH_FIFO_DRAINER_STATS_EN
        for (int i = 0; i < 20 && busy_o; i++) begin @(posedge clk_i); #1; end
        check("empty_polls", empty_polls_o, 32'(empty_cnt));
`endif
        chk_spacing = 1'b0;

        // Usage 10 with a stalled stream: credit limits to one buffer's worth.
        ready_i = 1'b0; w0 = word; p0 = pop_cnt; avail = pop_cnt + 10; pl = poll_cnt;
        repeat (80) begin @(posedge clk_i); #1; end
        check("burst_limited", 32'(pop_cnt - p0), 32'd4);
        check("stall_valid", 32'(valid_o), 32'd1);
        check("stall_data_held", data_o, w0);
        check("polls_continue", 32'(poll_cnt > pl + 2), 32'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 400 && (pop_cnt - p0 < 10 || exp_q.size() != 0); i++) begin
            @(posedge clk_i); #1;
        end
        check("resume_pops", 32'(pop_cnt - p0), 32'd10);
        check("resume_drained", 32'(exp_q.size()), 32'd0);

        // Slow grant: request must stay stable while waiting.
        gnt_delay = 5; p0 = pop_cnt; s0 = pop_wait_cycles; avail = pop_cnt + 1;
        for (int i = 0; i < 200 && pop_cnt < p0 + 1; i++) begin @(posedge clk_i); #1; end
        repeat (20) begin @(posedge clk_i); #1; end
        check("slow_gnt_pop", 32'(pop_cnt - p0), 32'd1);
        check("slow_gnt_waited", 32'(pop_wait_cycles - s0), 32'd5);
        check("slow_gnt_drained", 32'(exp_q.size()), 32'd0);
        gnt_delay = 0;

        // Enable dropped while a pop response is in flight.
        ready_i = 1'b0; w0 = word; p0 = pop_cnt; avail = pop_cnt + 3;
        for (int i = 0; i < 100 && pop_cnt < p0 + 1; i++) begin @(posedge clk_i); #1; end
        en_i = 1'b0;
        repeat (20) begin @(posedge clk_i); #1; end
        check("endrop_pops", 32'(pop_cnt - p0), 32'd1);
        check("endrop_busy", 32'(busy_o), 32'd0);
        check("endrop_req", 32'(req_o), 32'd0);
        check("endrop_valid", 32'(valid_o), 32'd1);
        check("endrop_data", data_o, w0);
        ready_i = 1'b1;
        repeat (5) begin @(posedge clk_i); #1; end
        check("endrop_delivered", 32'(exp_q.size()), 32'd0);

        // Reset while a pop response is outstanding; its late response must be dropped.
        ready_i = 1'b0; resp_delay = 3; p0 = pop_cnt; avail = pop_cnt + 2; en_i = 1'b1;
        for (int i = 0; i < 100 && pop_cnt < p0 + 1; i++) begin @(posedge clk_i); #1; end
        rst_i = 1'b1; en_i = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_req", 32'(req_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_add", add_o, BASE);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_data", data_o, 32'd0);
        rst_i = 1'b0;
        repeat (10) begin @(posedge clk_i); #1; end
        check("stale_ignored_valid", 32'(valid_o), 32'd0);
        check("stale_ignored_data", data_o, 32'd0);
        resp_delay = 1; ready_i = 1'b1; p0 = pop_cnt; avail = pop_cnt + 2; en_i = 1'b1;
        for (int i = 0; i < 200 && (pop_cnt - p0 < 2 || exp_q.size() != 0); i++) begin
            @(posedge clk_i); #1;
        end
        check("post_rst_pops", 32'(pop_cnt - p0), 32'd2);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);
`ifdef PERIPH_FIFO_DRAINER_STATS_EN
        check("words_count", words_o, 32'(xfer_cnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
